// File: rtl/uart_pkg.sv
// uart_pkg - shared state encoding, oversampling ratio and divider helper for the UART receiver.
// Rev 1.0
`default_nettype none

package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Clock cycles per oversample tick; integer division, never below 1.
    function automatic int unsigned calc_div(input int unsigned freq_clk,
                                             input int unsigned baud);
        int unsigned div;
        div = freq_clk / (OVERSAMPLE * baud);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_os_tick.sv
// uart_os_tick - free-running 0..DIV-1 counter giving a one-cycle oversample Tick, restartable by Clr.
// Rev 1.0
`default_nettype none

module uart_os_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clr,
    output logic Tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else if (Clr || (cnt_q == C_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign Tick = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// uart_receiver - 8N1 receiver with 16x oversampling, one-byte holding register, framing and overrun pulses.
// Rev 1.0
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter logic [31:0] FREQ_CLK = 32'd100000000,
    parameter logic [31:0] TX_SPEED = 32'd115200
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RXD,
    output logic [7:0] RX_Data,
    output logic       RX_Valid,
    input  logic       RX_Ready,
    output logic       Frame_Err,
    output logic       Overrun
);

    localparam int unsigned C_DIV  = calc_div(FREQ_CLK, TX_SPEED);
    localparam logic [3:0]  C_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  C_LAST = 4'(OVERSAMPLE - 1);

    logic       rxd_meta_q;
    logic       rxd_sync_q;
    logic       tick;
    logic       os_clr;

    rx_state_t  state_q,    state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] shift_q,    shift_d;

    logic       deliver;
    logic       frame_bad;

    logic [7:0] data_q;
    logic       valid_q;
    logic       ferr_q;
    logic       ovr_q;

    uart_os_tick #(
        .DIV (C_DIV)
    ) u_os_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .Clr  (os_clr),
        .Tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        os_clr     = 1'b0;
        deliver    = 1'b0;
        frame_bad  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxd_sync_q) begin
                    state_d    = START;
                    tick_cnt_d = 4'd0;
                    os_clr     = 1'b1;
                end
            end

            // Mid-bit re-check of the start bit filters short line glitches.
            START: begin
                if (tick) begin
                    if (tick_cnt_q == C_MID) begin
                        tick_cnt_d = 4'd0;
                        if (rxd_sync_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = 3'd0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == C_LAST) begin
                        shift_d   = {rxd_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == C_LAST) begin
                        if (rxd_sync_q) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_bad = 1'b1;
                            state_d   = BREAK;
                        end
                    end
                end
            end

            // A held-low line must go high before another start bit is accepted.
            BREAK: begin
                if (rxd_sync_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ferr_q     <= frame_bad;
            ovr_q      <= deliver && valid_q && !RX_Ready;

            // A delivery only lands when the slot is free or being emptied this cycle.
            if (deliver) begin
                if (!valid_q || RX_Ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && RX_Ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign RX_Data   = data_q;
    assign RX_Valid  = valid_q;
    assign Frame_Err = ferr_q;
    assign Overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver - directed and randomized frames checked against a one-slot consumer model.
// Rev 1.0
`default_nettype none

module tb_uart_receiver;

    localparam logic [31:0] C_FREQ    = 32'd6400000;
    localparam logic [31:0] C_SPEED   = 32'd100000;
    localparam int          C_BIT     = 64;
    localparam int          C_FRAME   = 10 * C_BIT;
    // Cycle (counted from the start-bit drive) in which the stop bit is sampled.
    localparam int          C_DELIVER = 2 + 4 * (8 + 16 * 9);

    logic       Clk = 1'b0;
    logic       Rst;
    logic       RXD;
    logic       RX_Ready;
    logic [7:0] RX_Data;
    logic       RX_Valid;
    logic       Frame_Err;
    logic       Overrun;

    always #5 Clk = ~Clk;

    uart_receiver #(
        .FREQ_CLK (C_FREQ),
        .TX_SPEED (C_SPEED)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RXD       (RXD),
        .RX_Data   (RX_Data),
        .RX_Valid  (RX_Valid),
        .RX_Ready  (RX_Ready),
        .Frame_Err (Frame_Err),
        .Overrun   (Overrun)
    );

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;

    logic [7:0] acc_q[$];
    int         valid_cycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         fe_run = 0;
    int         ov_run = 0;
    int         stab_err = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_fe = 1'b0;
    logic       prev_ov = 1'b0;

    always @(negedge Clk) begin
        if (Rst) begin
            prev_hold <= 1'b0;
            prev_fe   <= 1'b0;
            prev_ov   <= 1'b0;
        end else begin
            if (RX_Valid) valid_cycles <= valid_cycles + 1;
            if (RX_Valid && RX_Ready) acc_q.push_back(RX_Data);
            if (Frame_Err) fe_cnt <= fe_cnt + 1;
            if (Overrun) ov_cnt <= ov_cnt + 1;
            if (Frame_Err && prev_fe) fe_run <= fe_run + 1;
            if (Overrun && prev_ov) ov_run <= ov_run + 1;
            if (prev_hold && (!RX_Valid || (RX_Data !== prev_data))) stab_err <= stab_err + 1;
            prev_hold <= RX_Valid && !RX_Ready;
            prev_data <= RX_Data;
            prev_fe   <= Frame_Err;
            prev_ov   <= Overrun;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Drives one 8N1 frame; pulse_at raises RX_Ready for that single cycle, ncyc truncates the frame.
    task automatic send(input logic [7:0] d, input logic stopb, input logic base_ready,
                        input int pulse_at, input int ncyc);
        int b;
        for (int c = 0; c < ncyc; c++) begin
            b = c / C_BIT;
            if (b == 0)      RXD = 1'b0;
            else if (b <= 8) RXD = d[b-1];
            else             RXD = stopb;
            RX_Ready = (c == pulse_at) ? 1'b1 : base_ready;
            @(posedge Clk);
            #1;
        end
        RXD      = stopb ? 1'b1 : 1'b0;
        RX_Ready = base_ready;
    endtask

    logic [7:0] exp_q[$];
    int         acc_rd;
    int         v0, fe0, ov0;
    logic [7:0] ra, rb;

    initial begin
        Rst      = 1'b1;
        RXD      = 1'b1;
        RX_Ready = 1'b1;
        acc_rd   = 0;
        idle(3);
        check("rst_data",   {24'd0, RX_Data}, 32'h00);
        check("rst_valid",  {31'd0, RX_Valid}, 32'd0);
        check("rst_ferr",   {31'd0, Frame_Err}, 32'd0);
        check("rst_ovr",    {31'd0, Overrun}, 32'd0);
        Rst = 1'b0;
        idle(10);

        // Single byte with consumer always ready.
        v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
        send(8'hA5, 1'b1, 1'b1, -1, C_FRAME);
        idle(20);
        check("single_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("single_count", 32'(acc_q.size()), 32'(acc_rd + 1));
        if (acc_q.size() > acc_rd) check("single_data", {24'd0, acc_q[acc_rd]}, 32'hA5);
        check("single_errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
        acc_rd = acc_q.size();

        // Random bytes, random inter-frame gaps, always ready: every byte arrives in order.
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            exp_q.push_back(rb);
            send(rb, 1'b1, 1'b1, -1, C_FRAME);
            idle($urandom_range(0, 40));
        end
        idle(20);
        check("rand_count", 32'(acc_q.size() - acc_rd), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (acc_rd + i < acc_q.size()) check("rand_byte", {24'd0, acc_q[acc_rd + i]}, {24'd0, exp_q[i]});
        end
        acc_rd = acc_q.size();

        // Back-pressure: second byte is dropped with a single overrun pulse.
        ov0 = ov_cnt;
        RX_Ready = 1'b0;
        send(8'h3C, 1'b1, 1'b0, -1, C_FRAME);
        send(8'hC3, 1'b1, 1'b0, -1, C_FRAME);
        idle(10);
        check("bp_valid", {31'd0, RX_Valid}, 32'd1);
        check("bp_data", {24'd0, RX_Data}, 32'h3C);
        check("bp_overrun", 32'(ov_cnt - ov0), 32'd1);
        RX_Ready = 1'b1;
        idle(1);
        check("bp_valid_fall", {31'd0, RX_Valid}, 32'd0);
        check("bp_accept_count", 32'(acc_q.size()), 32'(acc_rd + 1));
        if (acc_q.size() > acc_rd) check("bp_accept", {24'd0, acc_q[acc_rd]}, 32'h3C);
        acc_rd = acc_q.size();

        // Randomized back-pressure pairs: first byte of each pair is the one kept.
        for (int i = 0; i < 2; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ov0 = ov_cnt;
            RX_Ready = 1'b0;
            send(ra, 1'b1, 1'b0, -1, C_FRAME);
            idle($urandom_range(0, 30));
            send(rb, 1'b1, 1'b0, -1, C_FRAME);
            idle(10);
            check("rbp_data", {24'd0, RX_Data}, {24'd0, ra});
            check("rbp_overrun", 32'(ov_cnt - ov0), 32'd1);
            RX_Ready = 1'b1;
            idle(2);
            if (acc_q.size() > acc_rd) check("rbp_accept", {24'd0, acc_q[acc_rd]}, {24'd0, ra});
            else check("rbp_accept_count", 32'(acc_q.size()), 32'(acc_rd + 1));
            acc_rd = acc_q.size();
        end

        // Handshake lands in the same cycle as a new delivery.
        ov0 = ov_cnt;
        RX_Ready = 1'b0;
        send(8'h11, 1'b1, 1'b0, -1, C_FRAME);
        idle(5);
        send(8'h5A, 1'b1, 1'b0, C_DELIVER, C_FRAME);
        idle(5);
        check("sim_valid", {31'd0, RX_Valid}, 32'd1);
        check("sim_data", {24'd0, RX_Data}, 32'h5A);
        check("sim_overrun", 32'(ov_cnt - ov0), 32'd0);
        if (acc_q.size() > acc_rd) check("sim_accept_old", {24'd0, acc_q[acc_rd]}, 32'h11);
        else check("sim_accept_count", 32'(acc_q.size()), 32'(acc_rd + 1));
        RX_Ready = 1'b1;
        idle(2);
        check("sim_accept_new", {24'd0, acc_q[acc_q.size() - 1]}, 32'h5A);
        acc_rd = acc_q.size();

        // Bad stop bit followed by a long break.
        v0 = valid_cycles; fe0 = fe_cnt;
        send(8'hFF, 1'b0, 1'b1, -1, C_FRAME);
        idle(2000);
        check("brk_ferr", 32'(fe_cnt - fe0), 32'd1);
        check("brk_no_valid", 32'(valid_cycles - v0), 32'd0);
        RXD = 1'b1;
        idle(20);
        send(8'h01, 1'b1, 1'b1, -1, C_FRAME);
        idle(20);
        check("brk_recover_count", 32'(acc_q.size()), 32'(acc_rd + 1));
        if (acc_q.size() > acc_rd) check("brk_recover", {24'd0, acc_q[acc_rd]}, 32'h01);
        check("brk_ferr_after", 32'(fe_cnt - fe0), 32'd1);
        acc_rd = acc_q.size();

        // Short low glitch on an idle line.
        v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
        RXD = 1'b0;
        idle(20);
        RXD = 1'b1;
        idle(100);
        check("glitch_valid", 32'(valid_cycles - v0), 32'd0);
        check("glitch_errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // Reset during data bit 4 while a byte is held.
        RX_Ready = 1'b0;
        rb = 8'($urandom);
        send(rb, 1'b1, 1'b0, -1, C_FRAME);
        idle(5);
        check("mid_held", {31'd0, RX_Valid}, 32'd1);
        fe0 = fe_cnt; ov0 = ov_cnt;
        send(8'h96, 1'b1, 1'b0, -1, 5 * C_BIT + 20);
        Rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, RX_Valid}, 32'd0);
        check("mid_rst_data", {24'd0, RX_Data}, 32'h00);
        check("mid_rst_pulses", {30'd0, Frame_Err, Overrun}, 32'd0);
        RXD = 1'b1;
        idle(3);
        Rst = 1'b0;
        idle(10);
        RX_Ready = 1'b1;
        send(8'h96, 1'b1, 1'b1, -1, C_FRAME);
        idle(20);
        check("mid_recover_count", 32'(acc_q.size()), 32'(acc_rd + 1));
        if (acc_q.size() > acc_rd) check("mid_recover", {24'd0, acc_q[acc_rd]}, 32'h96);
        check("mid_errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
        acc_rd = acc_q.size();

        check("hold_stability", 32'(stab_err), 32'd0);
        check("ferr_single_cycle", 32'(fe_run), 32'd0);
        check("ovr_single_cycle", 32'(ov_run), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter FREQ_CLK, logic [31:0], default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter TX_SPEED, logic [31:0], default 115200, line baud rate.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port RXD, input, 1 bit, asynchronous serial line, idle high.
REQ-006 The block SHALL have port RX_Data, output, 8 bits, received byte; valid while RX_Valid=1.
REQ-007 The block SHALL have port RX_Valid, output, 1 bit, a byte is held for the consumer.
REQ-008 The block SHALL have port RX_Ready, input, 1 bit, consumer accepts the held byte.
REQ-009 The block SHALL have port Frame_Err, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port Overrun, output, 1 bit, one-cycle pulse when a completed byte is dropped.

Function
REQ-011 RXD SHALL pass through a 2-flop synchronizer before use; both flops reset to 1.
REQ-012 The oversample tick SHALL be generated by a counter 0..DIV-1, where DIV = FREQ_CLK/(16*TX_SPEED) using integer division, with a minimum of 1.
REQ-013 The tick SHALL pulse for one cycle when the counter equals DIV-1; the counter SHALL restart at 0 on the IDLE-to-START transition.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, each transition as specified in REQ-015 to REQ-020.
REQ-015 IDLE: when synced RXD=0, the FSM SHALL go to START with the tick count cleared.
REQ-016 START: at the 8th tick (mid-bit), the FSM SHALL sample RXD; if RXD=1 it SHALL treat the event as a glitch and return to IDLE, otherwise it SHALL go to DATA with the bit count at 0.
REQ-017 DATA: every 16 ticks the FSM SHALL sample RXD into an LSB-first shift register; after the 8th bit it SHALL go to STOP.
REQ-018 STOP: after 16 ticks the FSM SHALL sample RXD; if RXD=1 it SHALL deliver the byte (REQ-021) and go to IDLE.
REQ-019 STOP: if the sample is 0, the FSM SHALL pulse Frame_Err, discard the byte and go to BREAK.
REQ-020 BREAK: the FSM SHALL stay until synced RXD=1, then go to IDLE; it SHALL NOT start new frames while the line is held low.
REQ-021 Delivery SHALL load the holding register and set RX_Valid on the cycle after the stop-bit sample.
REQ-022 RX_Valid SHALL stay 1 and RX_Data SHALL stay stable until a cycle with RX_Valid=1 and RX_Ready=1.
REQ-023 On a handshake cycle with no delivery, RX_Valid SHALL clear on the next cycle.
REQ-024 If delivery and handshake occur in the same cycle, the new byte SHALL load and RX_Valid SHALL remain 1.
REQ-025 If delivery occurs while RX_Valid=1 and RX_Ready=0, the new byte SHALL be dropped, the held byte kept, and Overrun SHALL pulse for one cycle.
REQ-026 Frame_Err and Overrun SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-027 Rst SHALL asynchronously force FSM=IDLE and clear the tick counter, bit counter and shift register to 0.
REQ-028 Rst SHALL asynchronously force RX_Data=8'h00, RX_Valid=0, Frame_Err=0 and Overrun=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no delivery and no error pulse.
REQ-030 After reset release, reception SHALL start only on a fresh low level of synced RXD.

Structure
REQ-031 The state enum typedef and the constant OVERSAMPLE=16 SHALL live in the shared package uart_pkg.
REQ-032 The tick generator SHALL be a separate sub-module, uart_os_tick, with ports Clk, Rst, Clr and Tick, and parameter DIV.
REQ-033 The FSM, shift register and output holding register SHALL be in uart_receiver.

Verification (FREQ_CLK=6400000, TX_SPEED=100000: DIV=4, 64 cycles per bit)
REQ-034 Scenario, single byte: send 8'hA5 with a valid stop bit while RX_Ready=1 -> exactly one RX_Valid cycle with RX_Data=8'hA5, no error pulses.
REQ-035 Scenario, back-pressure: send 8'h3C then 8'hC3 with RX_Ready=0 -> RX_Data stays 8'h3C, Overrun pulses once at the second stop bit; on raising RX_Ready, 8'h3C is accepted and RX_Valid falls.
REQ-036 Scenario, simultaneous: assert RX_Ready on the same cycle 8'h5A is delivered over held 8'h11 -> 8'h11 is accepted, 8'h5A is held, RX_Valid stays 1, no Overrun.
REQ-037 Scenario, framing/break: send 8'hFF with stop bit 0, then hold RXD low for 2000 cycles -> one Frame_Err pulse, no RX_Valid, FSM stays in BREAK; after RXD returns high, 8'h01 is received correctly.
REQ-038 Scenario, glitch: drive RXD low for 20 cycles -> FSM returns to IDLE, no RX_Valid, no errors.
REQ-039 Scenario, reset mid-frame: assert Rst during data bit 4 of 8'h96 -> all outputs reset per REQ-028; the next frame, 8'h96, is received correctly.
